// File: rtl/ofm_res_scheduler.sv
// ofm_res_scheduler
//   Sits in front of the OFM / residual store. For every output pixel and
//   timestep it gathers the three partial sums from the sum PEs (any order),
//   adds the pixel's stored residual potential, fires a spike against
//   THRESHOLD, then emits one spike packet to the OFM node and one residual
//   packet to each sum PE. Pixels are walked row-major, TIMESTEPS times.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               one-cycle pulse, starts a run from IDLE or DONE
//   in_data/valid/ready incoming packet stream (accepted only in COLLECT)
//   out_data/valid/ready outgoing packet stream (registered, held on stall)
//   cur_row/col/ts      current pixel / timestep
//   done                high while the run is complete
//   err                 pulses in the cycle a packet is dropped
module ofm_res_scheduler #(
  parameter int         WIDTH      = 35,
  parameter int         ROWS       = 28,
  parameter int         COLS       = 28,
  parameter int         TIMESTEPS  = 4,
  parameter int         THRESHOLD  = 64,
  parameter logic [3:0] SELF_ADDR  = 4'b1100,
  parameter logic [3:0] OFM_ADDR   = 4'b1110,
  parameter logic [3:0] SUM1_ADDR  = 4'b0001,
  parameter logic [3:0] SUM2_ADDR  = 4'b0011,
  parameter logic [3:0] SUM3_ADDR  = 4'b0111,
  parameter logic [1:0] PSUM_TYPE  = 2'b01,
  parameter logic [1:0] RES_TYPE   = 2'b10,
  parameter logic [1:0] SPIKE_TYPE = 2'b11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ROWS)-1:0]      cur_row,
  output logic [$clog2(COLS)-1:0]      cur_col,
  output logic [$clog2(TIMESTEPS)-1:0] cur_ts,
  output logic                         done,
  output logic                         err
);
  localparam int NPIX = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int TW   = $clog2(TIMESTEPS);
  localparam int PW   = $clog2(NPIX);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_COLLECT  = 3'd2;
  localparam logic [2:0] S_COMPUTE  = 3'd3;
  localparam logic [2:0] S_SEND_SPK = 3'd4;
  localparam logic [2:0] S_SEND_RES = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]    state;
  logic [PW-1:0] clr_idx;
  logic [7:0]    res_mem [NPIX];
  logic [2:0]    got;          // per-source "partial sum received" flags
  logic [7:0]    s1, s2, s3;
  logic [7:0]    nres_q;       // new residual, reused for all three res packets
  logic [1:0]    res_idx;

  // incoming packet decode
  logic [3:0] pkt_dest, pkt_src;
  logic [1:0] pkt_type, sel;
  logic       hit, pkt_ok, accept;
  logic [2:0] got_nxt;

  assign pkt_dest = in_data[34:31];
  assign pkt_src  = in_data[30:27];
  assign pkt_type = in_data[26:25];

  always_comb begin
    hit = 1'b1;
    sel = 2'd0;
    if (pkt_src == SUM1_ADDR)      sel = 2'd0;
    else if (pkt_src == SUM2_ADDR) sel = 2'd1;
    else if (pkt_src == SUM3_ADDR) sel = 2'd2;
    else                           hit = 1'b0;
  end

  assign in_ready = (state == S_COLLECT);
  assign done     = (state == S_DONE);
  assign accept   = in_valid && in_ready;
  assign pkt_ok   = (pkt_dest == SELF_ADDR) && (pkt_type == PSUM_TYPE) && hit && !got[sel];
  assign err      = accept && !pkt_ok;
  assign got_nxt  = got | (3'b001 << sel);

  // integrate-and-fire
  logic [PW-1:0] pix;
  logic [9:0]    total, diff;
  logic          spike;
  logic [7:0]    nres;

  assign pix   = PW'(cur_row) * PW'(COLS) + PW'(cur_col);
  assign total = 10'(s1) + 10'(s2) + 10'(s3) + 10'(res_mem[pix]);
  assign spike = (total >= 10'(THRESHOLD));
  assign diff  = spike ? total - 10'(THRESHOLD) : total;
  assign nres  = (diff > 10'd255) ? 8'hFF : diff[7:0];

  function automatic logic [3:0] sum_addr(input logic [1:0] k);
    case (k)
      2'd0:    sum_addr = SUM1_ADDR;
      2'd1:    sum_addr = SUM2_ADDR;
      default: sum_addr = SUM3_ADDR;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] res_pkt(input logic [1:0] k, input logic [7:0] v);
    res_pkt = {sum_addr(k), SELF_ADDR, RES_TYPE, 17'd0, v};
  endfunction

  logic col_last, row_last, ts_last;
  assign col_last = (cur_col == CW'(COLS - 1));
  assign row_last = (cur_row == RW'(ROWS - 1));
  assign ts_last  = (cur_ts  == TW'(TIMESTEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clr_idx   <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      cur_ts    <= '0;
      got       <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      nres_q    <= '0;
      res_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state   <= S_CLEAR;
          clr_idx <= '0;
        end
        S_CLEAR: begin
          if (clr_idx == PW'(NPIX - 1)) begin
            state   <= S_COLLECT;
            cur_row <= '0;
            cur_col <= '0;
            cur_ts  <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        S_COLLECT: if (accept && pkt_ok) begin
          case (sel)
            2'd0:    s1 <= in_data[7:0];
            2'd1:    s2 <= in_data[7:0];
            default: s3 <= in_data[7:0];
          endcase
          got <= got_nxt;
          if (&got_nxt) state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          nres_q    <= nres;
          got       <= '0;
          res_idx   <= '0;
          out_data  <= {OFM_ADDR, SELF_ADDR, SPIKE_TYPE, 24'd0, spike};
          out_valid <= 1'b1;
          state     <= S_SEND_SPK;
        end
        S_SEND_SPK: if (out_ready) begin
          // first residual packet follows the spike with no bubble
          out_data <= res_pkt(2'd0, nres_q);
          state    <= S_SEND_RES;
        end
        S_SEND_RES: if (out_ready) begin
          if (res_idx == 2'd2) begin
            out_valid <= 1'b0;
            res_idx   <= '0;
            if (col_last) begin
              cur_col <= '0;
              if (row_last) begin
                cur_row <= '0;
                if (ts_last) begin
                  cur_ts <= '0;
                  state  <= S_DONE;
                end else begin
                  cur_ts <= cur_ts + 1'b1;
                  state  <= S_COLLECT;
                end
              end else begin
                cur_row <= cur_row + 1'b1;
                state   <= S_COLLECT;
              end
            end else begin
              cur_col <= cur_col + 1'b1;
              state   <= S_COLLECT;
            end
          end else begin
            res_idx  <= res_idx + 1'b1;
            out_data <= res_pkt(res_idx + 1'b1, nres_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // residual store: no reset, zeroed by CLEAR at the start of every run
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)        res_mem[clr_idx] <= 8'd0;
    else if (state == S_COMPUTE) res_mem[pix]     <= nres;
  end

endmodule

// File: tb/tb_ofm_res_scheduler.sv
// Randomized bench for ofm_res_scheduler (2x2 map, 2 timesteps). A reference
// model holds per-pixel residuals as plain ints and predicts each pixel's
// spike and residual packets; a monitor collects accepted output packets and
// checks that stalled packets stay stable.
module tb_ofm_res_scheduler;
  localparam int ROWS = 2, COLS = 2, TS = 2, TH = 64;
  localparam logic [3:0] SELF = 4'b1100, OFM = 4'b1110;
  localparam logic [3:0] SUM1 = 4'b0001, SUM2 = 4'b0011, SUM3 = 4'b0111;

  logic        clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, done, err;
  logic [34:0] in_data, out_data;
  logic        cur_row, cur_col, cur_ts;

  ofm_res_scheduler #(.ROWS(ROWS), .COLS(COLS), .TIMESTEPS(TS), .THRESHOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cur_row(cur_row), .cur_col(cur_col), .cur_ts(cur_ts),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // output monitor
  logic [34:0] q[$];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_data;
  bit          rand_mode = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) q.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // reference model state
  int m_res[ROWS*COLS];
  int m_row, m_col, m_ts;

  task automatic model_clear();
    foreach (m_res[i]) m_res[i] = 0;
    m_row = 0; m_col = 0; m_ts = 0;
  endtask

  task automatic send_pkt(input logic [3:0] dest, input logic [3:0] src, input logic [1:0] typ,
                          input logic [7:0] d, input bit exp_ok);
    int n = 0;
    @(negedge clk);
    in_data  = {dest, src, typ, 17'd0, d};
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    else chk("err_flag", err, !exp_ok);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic start_run();
    int n = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    do begin
      @(negedge clk);
      if (!in_ready) n++;
    end while (!in_ready && n < 100);
    chk("clear_cycles", n, ROWS*COLS);
    model_clear();
  endtask

  task automatic do_pixel(input int a, input int b, input int c, input int mode,
                          input bit stall, output int got_res);
    int v[3];
    int ord[3];
    logic [3:0] sa[3];
    int pix, total, spk, nr, n, j, tmp;
    bit saved;
    logic [34:0] pk, exp_pkt;
    v = '{a, b, c};
    sa = '{SUM1, SUM2, SUM3};
    got_res = -1;
    saved = rand_mode;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("collect_enter", in_ready, 1);
    chk("cur_row", cur_row, m_row);
    chk("cur_col", cur_col, m_col);
    chk("cur_ts", cur_ts, m_ts);
    chk("no_extra_out", q.size(), 0);
    if (stall) begin rand_mode = 1'b0; out_ready = 1'b0; end
    if (mode == 1) begin
      send_pkt(SELF, SUM3, 2'b01, 8'(c), 1);
      send_pkt(SELF, SUM1, 2'b01, 8'(a), 1);
      send_pkt(SELF, SUM1, 2'b01, 8'(a) ^ 8'h5A, 0);
      send_pkt(4'b1101, SUM2, 2'b01, 8'(b), 0);
      send_pkt(SELF, SUM2, 2'b01, 8'(b), 1);
    end else begin
      ord = '{0, 1, 2};
      for (int i = 2; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      if ($urandom_range(0, 2) == 0) send_pkt(SELF, SUM1, 2'b10, 8'h33, 0);
      for (int k = 0; k < 3; k++) send_pkt(SELF, sa[ord[k]], 2'b01, 8'(v[ord[k]]), 1);
    end
    // integrate and fire on plain integers
    pix   = m_row * COLS + m_col;
    total = a + b + c + m_res[pix];
    spk   = (total >= TH) ? 1 : 0;
    nr    = spk ? total - TH : total;
    if (nr > 255) nr = 255;
    m_res[pix] = nr;
    if (stall) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      chk("spike_wait", out_valid, 1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    n = 0;
    while (q.size() < 4 && n < 300) begin @(negedge clk); n++; end
    chk("pkt_count", q.size() >= 4, 1);
    if (q.size() >= 4) begin
      exp_pkt = {OFM, SELF, 2'b11, 24'd0, 1'(spk)};
      pk = q.pop_front();
      chk("spike_pkt", pk, exp_pkt);
      for (int k = 0; k < 3; k++) begin
        exp_pkt = {sa[k], SELF, 2'b10, 17'd0, 8'(nr)};
        pk = q.pop_front();
        chk("res_pkt", pk, exp_pkt);
        got_res = int'(pk[7:0]);
      end
    end
    rand_mode = saved;
    m_col++;
    if (m_col == COLS) begin
      m_col = 0; m_row++;
      if (m_row == ROWS) begin m_row = 0; m_ts++; end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int r, n;
  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    start_run();
    // timestep 0
    do_pixel(10, 20, 40, 0, 0, r);
    chk("p00_residual", r, 6);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_ignored_rdy", in_ready, 1);
    chk("start_ignored_col", cur_col, 1);
    do_pixel(255, 255, 255, 0, 0, r);
    chk("saturate_residual", r, 255);
    rand_mode = 1'b1;
    do_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, r);
    do_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0, 1, r);
    // timestep 1
    do_pixel(0, 0, 0, 0, 0, r);
    chk("p00_ts1_residual", r, 6);
    for (int p = 0; p < 3; p++)
      do_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, r);
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done", done, 1);
    chk("done_in_ready", in_ready, 0);

    // reset while residual packets are pending
    rand_mode = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start_run();
    send_pkt(SELF, SUM1, 2'b01, 8'd10, 1);
    send_pkt(SELF, SUM2, 2'b01, 8'd20, 1);
    send_pkt(SELF, SUM3, 2'b01, 8'd40, 1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("abort_spike_wait", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_out", q.size(), 0);
    chk("abort_idle_rdy", in_ready, 0);
    start_run();
    do_pixel(0, 0, 0, 0, 0, r);
    chk("res_cleared", r, 0);
    do_pixel(1, 2, 3, 0, 0, r);
    chk("res_cleared_p1", r, 6);
    repeat (3) @(negedge clk);
    chk("final_no_out", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
